// File: rtl/paddle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paddle_pkg
// Brief    : Shared types, default playfield geometry and key decoding for
//            the paddle position controller.
// Revision : 1.0 - initial release
// ============================================================================
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } dir_t;

    localparam int VGA_XDIS  = 800;
    localparam int SIDE      = 40;
    localparam int STICK     = 100;
    localparam int X_MIN_DEF = SIDE - 1;
    localparam int X_MAX_DEF = VGA_XDIS - SIDE - STICK - 1;

    // Both keys together cancel out.
    function automatic dir_t decode_dir(input logic key_r, input logic key_l);
        dir_t d;
        d = NONE;
        if (key_r && !key_l) begin
            d = RIGHT;
        end else if (key_l && !key_r) begin
            d = LEFT;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/paddle_axis.sv
`default_nettype none
// ============================================================================
// Module   : paddle_axis
// Brief    : One player's press/hold/auto-repeat FSM and bounded X register.
//            Optional step acceleration under PADDLE_ACCEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_axis
    import paddle_pkg::*;
#(
    parameter int XW           = 10,
    parameter int X_MIN        = X_MIN_DEF,
    parameter int X_MAX        = X_MAX_DEF,
    parameter int X_INIT       = 349,
    parameter int STEP         = 20,
    parameter int WRAP         = 1,
    parameter int HOLD_TICKS   = 8,
    parameter int REPEAT_TICKS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          freeze,
    input  logic          key_r,
    input  logic          key_l,
    output logic [XW-1:0] x,
    output logic          moving
);

    localparam int          c_cnt_top = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int          c_cw      = $clog2(c_cnt_top + 1);
    localparam logic [XW:0] c_x_min   = (XW+1)'(X_MIN);
    localparam logic [XW:0] c_x_max   = (XW+1)'(X_MAX);

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic            r_key_r_q;
    logic            r_key_l_q;
    logic [XW-1:0]   r_x;
    logic            r_moving;

    dir_t            w_dir;
    dir_t            w_prev_dir;
    logic            w_dir_same;
    logic            w_tick_done;
    logic            w_do_step;
    logic [c_cw-1:0] w_cnt_inc;
    logic [XW:0]     w_step;
    logic [XW:0]     w_sum;
    logic [XW-1:0]   w_diff;
    logic [XW-1:0]   w_x_next;

    assign w_dir      = decode_dir(key_r, key_l);
    assign w_prev_dir = decode_dir(r_key_r_q, r_key_l_q);
    assign w_dir_same = (w_dir == w_prev_dir);
    assign w_cnt_inc  = r_cnt + c_cw'(1);

    always_comb begin
        w_tick_done = 1'b0;
        if (tick) begin
            if (r_state == DELAY) begin
                w_tick_done = (w_cnt_inc == c_cw'(HOLD_TICKS));
            end else if (r_state == REPEAT) begin
                w_tick_done = (w_cnt_inc == c_cw'(REPEAT_TICKS));
            end
        end
    end

    // A fresh press (from IDLE) or a reversal steps at once; otherwise wait for the tick budget.
    always_comb begin
        w_do_step = 1'b0;
        if (!freeze && (w_dir != NONE)) begin
            if ((r_state == IDLE) || !w_dir_same) begin
                w_do_step = 1'b1;
            end else begin
                w_do_step = w_tick_done;
            end
        end
    end

`ifdef PADDLE_ACCEL_EN
    // Counts auto-repeat steps; the fifth and later ones use double stride.
    logic [2:0] r_acc;
    logic       w_rep_step;

    assign w_rep_step = !freeze && (w_dir != NONE) && w_dir_same && w_tick_done;
    assign w_step     = (w_rep_step && (r_acc == 3'd4)) ? (XW+1)'(2 * STEP) : (XW+1)'(STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 3'd0;
        end else if (w_rep_step) begin
            if (r_acc != 3'd4) begin
                r_acc <= r_acc + 3'd1;
            end
        end else if (freeze || (r_state == IDLE) || (w_dir == NONE) || !w_dir_same) begin
            r_acc <= 3'd0;
        end
    end
`else
    assign w_step = (XW+1)'(STEP);
`endif

    assign w_sum  = {1'b0, r_x} + w_step;
    assign w_diff = r_x - w_step[XW-1:0];

    always_comb begin
        w_x_next = r_x;
        if (w_dir == RIGHT) begin
            if (w_sum <= c_x_max) begin
                w_x_next = w_sum[XW-1:0];
            end else begin
                w_x_next = (WRAP != 0) ? XW'(X_MIN) : XW'(X_MAX);
            end
        end else if (w_dir == LEFT) begin
            if ({1'b0, r_x} >= (c_x_min + w_step)) begin
                w_x_next = w_diff;
            end else begin
                w_x_next = (WRAP != 0) ? XW'(X_MAX) : XW'(X_MIN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_key_r_q <= 1'b0;
            r_key_l_q <= 1'b0;
            r_x       <= XW'(X_INIT);
            r_moving  <= 1'b0;
        end else begin
            r_key_r_q <= key_r;
            r_key_l_q <= key_l;
            r_moving  <= w_do_step && (w_x_next != r_x);
            if (w_do_step) begin
                r_x <= w_x_next;
            end
            if (freeze) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (w_dir != NONE) begin
                            r_state <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (w_dir == NONE) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (!w_dir_same) begin
                            r_state <= DELAY;
                            r_cnt   <= '0;
                        end else if (w_tick_done) begin
                            r_state <= REPEAT;
                            r_cnt   <= '0;
                        end else if (tick) begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign x      = r_x;
    assign moving = r_moving;

endmodule
`default_nettype wire

// File: rtl/paddle_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ctrl_multi
// Brief    : NUM_PLAYERS independent paddle X controllers for the 800x600
//            field. Define PADDLE_ACCEL_EN for accelerated auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_ctrl_multi
    import paddle_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int XW           = 10,
    parameter int X_MIN        = X_MIN_DEF,
    parameter int X_MAX        = X_MAX_DEF,
    parameter int X_INIT       = 349,
    parameter int STEP         = 20,
    parameter int WRAP         = 1,
    parameter int HOLD_TICKS   = 8,
    parameter int REPEAT_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      freeze,
    input  logic [NUM_PLAYERS-1:0]    key_r,
    input  logic [NUM_PLAYERS-1:0]    key_l,
    output logic [NUM_PLAYERS*XW-1:0] x,
    output logic [NUM_PLAYERS-1:0]    moving
);

    generate
        if ((X_MIN + STEP > X_MAX) || (X_INIT < X_MIN) || (X_INIT > X_MAX) ||
            (X_MAX >= (1 << XW))) begin : g_bad_params
            $error("paddle_ctrl_multi: illegal geometry parameters");
        end
    endgenerate

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        paddle_axis #(
            .XW           (XW),
            .X_MIN        (X_MIN),
            .X_MAX        (X_MAX),
            .X_INIT       (X_INIT),
            .STEP         (STEP),
            .WRAP         (WRAP),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_axis (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .freeze (freeze),
            .key_r  (key_r[p]),
            .key_l  (key_l[p]),
            .x      (x[p*XW +: XW]),
            .moving (moving[p])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_ctrl_multi
// Brief    : Directed bench for paddle_ctrl_multi; a wrapping and a clamping
//            instance share all stimulus. Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl_multi;

`ifdef PADDLE_ACCEL_EN
    localparam int ACC_LAST = 179;
`else
    localparam int ACC_LAST = 159;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        freeze;
    logic [1:0]  key_r;
    logic [1:0]  key_l;
    logic [19:0] x_w;
    logic [19:0] x_c;
    logic [1:0]  mov_w;
    logic [1:0]  mov_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    paddle_ctrl_multi #(.WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .tick(tick), .freeze(freeze),
        .key_r(key_r), .key_l(key_l), .x(x_w), .moving(mov_w)
    );

    paddle_ctrl_multi #(.WRAP(0)) dut_clamp (
        .clk(clk), .rst_n(rst_n), .tick(tick), .freeze(freeze),
        .key_r(key_r), .key_l(key_l), .x(x_c), .moving(mov_c)
    );

    task automatic tick_pulse();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic press(input int p, input logic right);
        @(posedge clk); #1;
        if (right) key_r[p] = 1'b1; else key_l[p] = 1'b1;
        @(posedge clk); #1;
        key_r[p] = 1'b0;
        key_l[p] = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0; tick = 1'b0; freeze = 1'b0; key_r = '0; key_l = '0;
        repeat (3) @(posedge clk);
        #1;
        if (x_w !== {10'd349, 10'd349} || mov_w !== 2'b00) begin
            n_bad++; $display("FAIL reset_wrap: x1=%0d x0=%0d mov=%b, want 349 349 00", x_w[19:10], x_w[9:0], mov_w);
        end
        n_cmp++;
        if (x_c !== {10'd349, 10'd349} || mov_c !== 2'b00) begin
            n_bad++; $display("FAIL reset_clamp: x1=%0d x0=%0d mov=%b, want 349 349 00", x_c[19:10], x_c[9:0], mov_c);
        end
        n_cmp++;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            tick = (i % 4 == 0);
            if ((mov_w | mov_c) != 2'b00) seen = 1'b1;
        end
        tick = 1'b0;
        if (x_w !== {10'd349, 10'd349} || x_c !== {10'd349, 10'd349} || seen !== 1'b0) begin
            n_bad++; $display("FAIL idle_100: wrap x1=%0d x0=%0d clamp x1=%0d x0=%0d moved=%b, want 349s and 0",
                              x_w[19:10], x_w[9:0], x_c[19:10], x_c[9:0], seen);
        end
        n_cmp++;
    endtask

    task automatic test_single_step();
        press(0, 1'b1);
        if (x_w !== {10'd349, 10'd369} || mov_w !== 2'b01) begin
            n_bad++; $display("FAIL single_step_wrap: x1=%0d x0=%0d mov=%b, want 349 369 01", x_w[19:10], x_w[9:0], mov_w);
        end
        n_cmp++;
        if (x_c !== {10'd349, 10'd369} || mov_c !== 2'b01) begin
            n_bad++; $display("FAIL single_step_clamp: x1=%0d x0=%0d mov=%b, want 349 369 01", x_c[19:10], x_c[9:0], mov_c);
        end
        n_cmp++;
        @(posedge clk); #1;
        if (x_w !== {10'd349, 10'd369} || mov_w !== 2'b00) begin
            n_bad++; $display("FAIL single_step_drop: x0=%0d mov=%b, want 369 00", x_w[9:0], mov_w);
        end
        n_cmp++;
    endtask

    task automatic test_hold_repeat();
        int exp_x1[2] = '{289, 269};
        @(posedge clk); #1 key_l[1] = 1'b1;
        @(posedge clk); #1;
        if (x_w !== {10'd329, 10'd369} || mov_w !== 2'b10) begin
            n_bad++; $display("FAIL hold_press: x1=%0d x0=%0d mov=%b, want 329 369 10", x_w[19:10], x_w[9:0], mov_w);
        end
        n_cmp++;
        repeat (7) tick_pulse();
        if (x_w[19:10] !== 10'd329 || mov_w !== 2'b00) begin
            n_bad++; $display("FAIL hold_tick7: x1=%0d mov=%b, want 329 00", x_w[19:10], mov_w);
        end
        n_cmp++;
        tick_pulse();
        if (x_w[19:10] !== 10'd309 || mov_w !== 2'b10) begin
            n_bad++; $display("FAIL hold_tick8: x1=%0d mov=%b, want 309 10", x_w[19:10], mov_w);
        end
        n_cmp++;
        tick_pulse();
        if (x_w[19:10] !== 10'd309 || mov_w !== 2'b00) begin
            n_bad++; $display("FAIL hold_tick9: x1=%0d mov=%b, want 309 00", x_w[19:10], mov_w);
        end
        n_cmp++;
        for (int k = 0; k < 2; k++) begin
            if (k != 0) tick_pulse();
            tick_pulse();
            if (x_w[19:10] !== 10'(exp_x1[k]) || mov_w !== 2'b10) begin
                n_bad++; $display("FAIL hold_repeat%0d: x1=%0d mov=%b, want %0d 10", k, x_w[19:10], mov_w, exp_x1[k]);
            end
            n_cmp++;
        end
        key_l[1] = 1'b0;
        if (x_c !== {10'd269, 10'd369}) begin
            n_bad++; $display("FAIL hold_clamp: x1=%0d x0=%0d, want 269 369", x_c[19:10], x_c[9:0]);
        end
        n_cmp++;
    endtask

    task automatic test_both_keys();
        @(posedge clk); #1 key_r[0] = 1'b1; key_l[0] = 1'b1;
        @(posedge clk); #1;
        if (x_w !== {10'd269, 10'd369} || mov_w !== 2'b00) begin
            n_bad++; $display("FAIL both_keys_edge: x1=%0d x0=%0d mov=%b, want 269 369 00", x_w[19:10], x_w[9:0], mov_w);
        end
        n_cmp++;
        repeat (10) tick_pulse();
        key_r[0] = 1'b0; key_l[0] = 1'b0;
        if (x_w !== {10'd269, 10'd369} || x_c !== {10'd269, 10'd369}) begin
            n_bad++; $display("FAIL both_keys_ticks: wrap x0=%0d clamp x0=%0d, want 369 369", x_w[9:0], x_c[9:0]);
        end
        n_cmp++;
    endtask

    task automatic test_freeze();
        @(posedge clk); #1 freeze = 1'b1; key_r[0] = 1'b1;
        repeat (10) tick_pulse();
        if (x_w[9:0] !== 10'd369 || x_c[9:0] !== 10'd369 || (mov_w | mov_c) !== 2'b00) begin
            n_bad++; $display("FAIL freeze_hold: wrap x0=%0d clamp x0=%0d mov=%b/%b, want 369 369 00", x_w[9:0], x_c[9:0], mov_w, mov_c);
        end
        n_cmp++;
        freeze = 1'b0;
        @(posedge clk); #1;
        if (x_w !== {10'd269, 10'd389} || mov_w !== 2'b01) begin
            n_bad++; $display("FAIL freeze_release: x1=%0d x0=%0d mov=%b, want 269 389 01", x_w[19:10], x_w[9:0], mov_w);
        end
        n_cmp++;
        @(posedge clk); #1;
        key_r[0] = 1'b0;
        if (x_w[9:0] !== 10'd389 || mov_w !== 2'b00) begin
            n_bad++; $display("FAIL freeze_delay: x0=%0d mov=%b, want 389 00", x_w[9:0], mov_w);
        end
        n_cmp++;
    endtask

    task automatic test_bounds();
        for (int i = 0; i < 17; i++) press(0, 1'b0);
        if (x_w[9:0] !== 10'd49 || x_c[9:0] !== 10'd49) begin
            n_bad++; $display("FAIL bounds_walk_left: wrap=%0d clamp=%0d, want 49 49", x_w[9:0], x_c[9:0]);
        end
        n_cmp++;
        press(0, 1'b0);
        if ({x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]} !== {10'd659, 1'b1, 10'd39, 1'b1}) begin
            n_bad++; $display("FAIL bounds_left_low: wrap=%0d/%b clamp=%0d/%b, want 659/1 39/1", x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]);
        end
        n_cmp++;
        press(0, 1'b1);
        if ({x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]} !== {10'd39, 1'b1, 10'd59, 1'b1}) begin
            n_bad++; $display("FAIL bounds_right_wrap: wrap=%0d/%b clamp=%0d/%b, want 39/1 59/1", x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]);
        end
        n_cmp++;
        press(0, 1'b0);
        if ({x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]} !== {10'd659, 1'b1, 10'd39, 1'b1}) begin
            n_bad++; $display("FAIL bounds_left_wrap: wrap=%0d/%b clamp=%0d/%b, want 659/1 39/1", x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]);
        end
        n_cmp++;
        press(0, 1'b0);
        if ({x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]} !== {10'd639, 1'b1, 10'd39, 1'b0}) begin
            n_bad++; $display("FAIL bounds_clamp_min: wrap=%0d/%b clamp=%0d/%b, want 639/1 39/0", x_w[9:0], mov_w[0], x_c[9:0], mov_c[0]);
        end
        n_cmp++;
        for (int i = 0; i < 19; i++) press(1, 1'b1);
        if (x_w[19:10] !== 10'd649 || x_c[19:10] !== 10'd649) begin
            n_bad++; $display("FAIL bounds_walk_right: wrap=%0d clamp=%0d, want 649 649", x_w[19:10], x_c[19:10]);
        end
        n_cmp++;
        press(1, 1'b1);
        if ({x_w[19:10], mov_w[1], x_c[19:10], mov_c[1]} !== {10'd39, 1'b1, 10'd659, 1'b1}) begin
            n_bad++; $display("FAIL bounds_right_high: wrap=%0d/%b clamp=%0d/%b, want 39/1 659/1", x_w[19:10], mov_w[1], x_c[19:10], mov_c[1]);
        end
        n_cmp++;
        press(1, 1'b1);
        if ({x_w[19:10], mov_w[1], x_c[19:10], mov_c[1]} !== {10'd59, 1'b1, 10'd659, 1'b0}) begin
            n_bad++; $display("FAIL bounds_clamp_max: wrap=%0d/%b clamp=%0d/%b, want 59/1 659/0", x_w[19:10], mov_w[1], x_c[19:10], mov_c[1]);
        end
        n_cmp++;
    endtask

    task automatic test_accel();
        int exp_rep[4] = '{99, 119, 139, ACC_LAST};
        @(posedge clk); #1 key_r[0] = 1'b1;
        @(posedge clk); #1;
        if (x_c[9:0] !== 10'd59 || mov_c !== 2'b01) begin
            n_bad++; $display("FAIL accel_press: x0=%0d mov=%b, want 59 01", x_c[9:0], mov_c);
        end
        n_cmp++;
        repeat (8) tick_pulse();
        if (x_c[9:0] !== 10'd79) begin
            n_bad++; $display("FAIL accel_hold: x0=%0d, want 79", x_c[9:0]);
        end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            repeat (2) tick_pulse();
            if (x_c[9:0] !== 10'(exp_rep[k]) || mov_c !== 2'b01) begin
                n_bad++; $display("FAIL accel_repeat%0d: x0=%0d mov=%b, want %0d 01", k, x_c[9:0], mov_c, exp_rep[k]);
            end
            n_cmp++;
        end
        key_r[0] = 1'b0;
        if (x_c[19:10] !== 10'd659) begin
            n_bad++; $display("FAIL accel_independent: x1=%0d, want 659", x_c[19:10]);
        end
        n_cmp++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_step();
        test_hold_repeat();
        test_both_keys();
        test_freeze();
        test_bounds();
        test_accel();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
